// File: rtl/pb_debouncer_multi.sv
// N-channel push-button conditioner: synchroniser, exact-count debounce, press/release/long pulses.
// Optional auto-repeat pulse train is built only when PB_AUTOREPEAT_EN is defined.
module pb_debouncer_multi #(
    parameter int N_CH          = 4,
    parameter int DELAY         = 15,
    parameter int LONG_DELAY    = 1000,
    parameter int REPEAT_PERIOD = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] PB,
    output logic [N_CH-1:0] PB_pressed_status,
    output logic [N_CH-1:0] PB_pressed_pulse,
    output logic [N_CH-1:0] PB_released_pulse,
    output logic [N_CH-1:0] PB_long_status,
    output logic [N_CH-1:0] PB_long_pulse,
    output logic [N_CH-1:0] PB_repeat_pulse
);
    localparam int CW = $clog2(DELAY);
    localparam int HW = $clog2(LONG_DELAY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_DELAY);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_DELAY - 1);

    if (N_CH < 1 || DELAY < 2 || LONG_DELAY <= DELAY || REPEAT_PERIOD < 2) begin : g_param_check
        $error("pb_debouncer_multi: illegal parameter set");
    end

    logic [N_CH-1:0] sync_aux;
    logic [N_CH-1:0] sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_aux <= '0;
            sync     <= '0;
        end else begin
            sync_aux <= PB;
            sync     <= sync_aux;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [HW-1:0] hold;
        logic          status;
        logic          pressed;
        logic          released;
        logic          long_status;
        logic          long_pulse;
        logic          rep_pulse;
        logic          accept;
        logic          long_fire;

        assign accept    = (sync[i] != status) && (cnt == CNT_LAST);
        // An accepted release on the would-be long-press edge suppresses the long event.
        assign long_fire = status && !accept && (hold == HOLD_PRE);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt         <= '0;
                hold        <= '0;
                status      <= 1'b0;
                pressed     <= 1'b0;
                released    <= 1'b0;
                long_status <= 1'b0;
                long_pulse  <= 1'b0;
            end else begin
                pressed    <= accept && !status;
                released   <= accept && status;
                long_pulse <= long_fire;

                if (sync[i] == status || accept)
                    cnt <= '0;
                else
                    cnt <= cnt + 1'b1;

                if (accept)
                    status <= ~status;

                if (!status || accept) begin
                    hold        <= '0;
                    long_status <= 1'b0;
                end else if (hold != HOLD_MAX) begin
                    hold <= hold + 1'b1;
                end

                if (long_fire)
                    long_status <= 1'b1;
            end
        end

`ifdef PB_AUTOREPEAT_EN
        localparam int RW = $clog2(REPEAT_PERIOD);
        localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_PERIOD - 1);
        logic [RW-1:0] rep_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rep_cnt   <= '0;
                rep_pulse <= 1'b0;
            end else begin
                rep_pulse <= 1'b0;
                if (!status || accept) begin
                    rep_cnt <= '0;
                end else if (long_fire) begin
                    rep_pulse <= 1'b1;
                    rep_cnt   <= '0;
                end else if (long_status) begin
                    if (rep_cnt == REP_LAST) begin
                        rep_pulse <= 1'b1;
                        rep_cnt   <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
            end
        end
`else
        assign rep_pulse = 1'b0;
`endif

        assign PB_pressed_status[i] = status;
        assign PB_pressed_pulse[i]  = pressed;
        assign PB_released_pulse[i] = released;
        assign PB_long_status[i]    = long_status;
        assign PB_long_pulse[i]     = long_pulse;
        assign PB_repeat_pulse[i]   = rep_pulse;
    end
endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Directed bench for pb_debouncer_multi with DELAY=4, LONG_DELAY=20, REPEAT_PERIOD=5, N_CH=4.
// Repeat expectations follow PB_AUTOREPEAT_EN, matching how the DUT is built.
module tb_pb_debouncer_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] PB  = 4'b0000;
    logic [3:0] ps, pp, rp, ls, lp, rep;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    pb_debouncer_multi #(
        .N_CH(4), .DELAY(4), .LONG_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .PB(PB),
        .PB_pressed_status(ps),
        .PB_pressed_pulse(pp),
        .PB_released_pulse(rp),
        .PB_long_status(ls),
        .PB_long_pulse(lp),
        .PB_repeat_pulse(rep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) step();
    endtask

    // Leaves time just after an edge with reset released; the next edge is edge 0.
    task automatic do_reset();
        PB  = 4'b0000;
        rst = 1'b0;
        step();
        step();
        rst    = 1'b1;
        edge_n = -1;
    endtask

    logic [23:0] all_out;
    assign all_out = {ps, pp, rp, ls, lp, rep};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rep_on;
        logic [15:0] bounce;
        logic [3:0]  e_ps, e_pp, e_rp, e_ls, e_lp, e_rep;
`ifdef PB_AUTOREPEAT_EN
        rep_on = 1'b1;
`else
        rep_on = 1'b0;
`endif
        #1 rst = 1'b0;
        #1 chk("reset_async", 32'(all_out), 32'h0);

        // 1: clean press on channel 0, first sampled at edge 10
        do_reset();
        run_to(9);
        PB = 4'b0001;
        for (int e = 10; e <= 16; e++) begin
            run_to(e);
            chk("t1_press_pulse", 32'(pp), (e == 15) ? 32'h1 : 32'h0);
            chk("t1_status", 32'(ps), (e >= 15) ? 32'h1 : 32'h0);
        end
        PB = 4'b0000;
        run_to(21);
        chk("t1_status_before_rel", 32'(ps), 32'h1);
        run_to(22);
        chk("t1_release_pulse", 32'({ps, rp}), 32'h01);
        run_to(23);
        chk("t1_release_clear", 32'(rp), 32'h0);

        // 2: bounce on channel 1 -- high 3, low 1, high 3, low
        do_reset();
        bounce = 16'b0000_0000_0111_0111;
        for (int e = 0; e < 16; e++) begin
            PB[1] = bounce[e];
            step();
            chk("t2_bounce", 32'(all_out), 32'h0);
        end

        // 3/4: long press and repeat on channel 2
        do_reset();
        PB = 4'b0100;
        for (int e = 0; e <= 47; e++) begin
            if (e == 37) PB = 4'b0000;
            step();
            e_ps  = (e >= 5 && e < 42)  ? 4'b0100 : 4'b0000;
            e_pp  = (e == 5)            ? 4'b0100 : 4'b0000;
            e_rp  = (e == 42)           ? 4'b0100 : 4'b0000;
            e_ls  = (e >= 25 && e < 42) ? 4'b0100 : 4'b0000;
            e_lp  = (e == 25)           ? 4'b0100 : 4'b0000;
            e_rep = (rep_on && (e == 25 || e == 30 || e == 35 || e == 40)) ? 4'b0100 : 4'b0000;
            chk("t3_long_repeat", 32'(all_out), 32'({e_ps, e_pp, e_rp, e_ls, e_lp, e_rep}));
        end

        // 5: all channels pressed together
        do_reset();
        PB = 4'b1111;
        run_to(4);
        chk("t5_before", 32'({ps, pp}), 32'h00);
        run_to(5);
        chk("t5_all_pressed", 32'({ps, pp}), 32'hFF);
        run_to(6);
        chk("t5_pulse_single", 32'(pp), 32'h0);

        // 6: async reset mid-count, then full latency restarts
        do_reset();
        PB = 4'b0001;
        run_to(5);
        chk("t6_ch0_pressed", 32'(ps), 32'h1);
        run_to(9);
        PB = 4'b0011;
        run_to(13);
        #3 rst = 1'b0;
        #1 chk("t6_async_clear", 32'(all_out), 32'h0);
        #2 rst = 1'b1;
        run_to(18);
        chk("t6_latency_hold", 32'({ps, pp}), 32'h00);
        run_to(19);
        chk("t6_latency_done", 32'({ps, pp}), 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
